// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end. Issues one word-aligned fetch at a time to
// instruction memory, captures the returned word into the instruction
// register and presents it, already split into MIPS fields, to the decode /
// control stage through a valid/ready handshake. Taken branches and jumps
// arrive as single-cycle redirects; any fetch that was in flight when the
// redirect arrived is discarded when its response returns.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   imem_req_valid/ready fetch request handshake to instruction memory
//   imem_addr           fetch address (always word aligned)
//   imem_rsp_valid/data response word, one pulse per accepted request
//   redirect_valid/pc   branch/jump target; low two address bits ignored
//   instr_valid/ready   decoded-instruction handshake to downstream
//   instr_op .. funct   R/I-type fields of the held instruction
//   instr_imm_sext      immediate field sign-extended to 32 bits
//   instr_pc(_plus4)    fetch address of the held instruction, and +4
//   fetch_count         instructions delivered (valid & ready), wrapping
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,

  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,

  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,

  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [5:0]        instr_op,
  output logic [4:0]        instr_rs,
  output logic [4:0]        instr_rt,
  output logic [4:0]        instr_rd,
  output logic [4:0]        instr_shamt,
  output logic [5:0]        instr_funct,
  output logic [31:0]       instr_imm_sext,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc_plus4,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // one quiet cycle after reset
    ST_REQ  = 2'd1,  // request presented, waiting for memory to accept
    ST_WAIT = 2'd2,  // request accepted, waiting for the response word
    ST_HOLD = 2'd3   // instruction held for downstream
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              drop;          // response of the in-flight fetch is stale
  logic              req_valid_q;
  logic              instr_valid_q;
  logic [15:0]       fetch_count_q;

  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] pc_seq;

  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign pc_seq          = pc + PC_STEP;  // wraps modulo 2^ADDR_W

  // NOTE: every register below is assigned with <= so that all of them sample
  // the pre-edge values of each other; mixing in = here would make the result
  // depend on statement order inside the block.
  // NOTE: ir is a single datapath register, not an array, and the decoded
  // fields must read zero out of reset, so it is reset along with the control
  // state rather than left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      ir            <= '0;
      instr_pc_q    <= RESET_PC;
      drop          <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid) pc <= redirect_target;
          state       <= ST_REQ;
          req_valid_q <= 1'b1;
        end

        ST_REQ: begin
          // pc drives imem_addr directly, so it only moves on a redirect and
          // the address is otherwise held while the request is not accepted.
          if (redirect_valid) pc <= redirect_target;
          if (imem_req_ready) begin
            state       <= ST_WAIT;
            req_valid_q <= 1'b0;
            // A redirect coinciding with acceptance leaves an old-pc fetch
            // in flight whose word must be thrown away.
            drop        <= redirect_valid;
          end
        end

        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop || redirect_valid) begin
              if (redirect_valid) pc <= redirect_target;
              drop        <= 1'b0;
              state       <= ST_REQ;
              req_valid_q <= 1'b1;
            end else begin
              ir            <= imem_rsp_data;
              instr_pc_q    <= pc;
              pc            <= pc_seq;
              instr_valid_q <= 1'b1;
              state         <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_target;
            drop <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (redirect_valid) pc <= redirect_target;
          // A handshake in the redirect cycle still counts as delivered; a
          // redirect alone squashes the held instruction uncounted.
          if (instr_ready) fetch_count_q <= fetch_count_q + 16'd1;
          if (instr_ready || redirect_valid) begin
            instr_valid_q <= 1'b0;
            state         <= ST_REQ;
            req_valid_q   <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc;

  assign instr_valid    = instr_valid_q;
  assign instr_op       = ir[31:26];
  assign instr_rs       = ir[25:21];
  assign instr_rt       = ir[20:16];
  assign instr_rd       = ir[15:11];
  assign instr_shamt    = ir[10:6];
  assign instr_funct    = ir[5:0];
  assign instr_imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = instr_pc_q + PC_STEP;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed scenarios followed by a randomized run. A memory responder answers
// each accepted request after a programmable latency. The reference model is a
// queue holding the address of the next instruction that must be delivered:
// sequential flow appends pc+4 after each delivery, a redirect replaces the
// contents with the aligned target. A monitor pops and compares on every
// delivery handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  instr_op;
  logic [4:0]  instr_rs;
  logic [4:0]  instr_rt;
  logic [4:0]  instr_rd;
  logic [4:0]  instr_shamt;
  logic [5:0]  instr_funct;
  logic [31:0] instr_imm_sext;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic [15:0] fetch_count;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_rs       (instr_rs),
    .instr_rt       (instr_rt),
    .instr_rd       (instr_rd),
    .instr_shamt    (instr_shamt),
    .instr_funct    (instr_funct),
    .instr_imm_sext (instr_imm_sext),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory contents: a few fixed words, a hash elsewhere.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h3C6E_F372;
  endfunction

  // Reference model / scoreboard state (owned by the monitor).
  logic [31:0] exp_q[$];
  logic [15:0] exp_count;
  int          deliveries = 0;
  logic        acc_pending = 1'b0;  // request accepted at the coming edge
  logic [31:0] acc_addr    = '0;

  // Stimulus-controlled memory behaviour.
  int   mem_lat     = 1;     // 0 selects a random latency of 1..3 cycles
  logic inject_junk = 1'b0;  // drive one unsolicited response word

  // Monitor: samples on the falling edge, i.e. the values the DUT will see at
  // the next rising edge.
  initial begin
    logic [31:0] e;
    logic [31:0] w;
    logic        popped;
    logic        prev_stall;
    logic [31:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        exp_count   = '0;
        prev_stall  = 1'b0;
        acc_pending = 1'b0;
      end else begin
        if (imem_req_valid) check("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
        if (prev_stall) begin
          check("req_held", 32'(imem_req_valid), 32'd1);
          check("addr_held", imem_addr, prev_addr);
        end
        prev_stall  = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr   = imem_addr;
        acc_pending = imem_req_valid && imem_req_ready;
        acc_addr    = imem_addr;

        popped = 1'b0;
        if (instr_valid && instr_ready) begin
          deliveries++;
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb_unexpected: delivered pc 0x%08h, expected none", instr_pc);
          end else begin
            e      = exp_q.pop_front();
            w      = mem_word(e);
            popped = 1'b1;
            check("sb_pc", instr_pc, e);
            check("sb_pc_plus4", instr_pc_plus4, e + 32'd4);
            check("sb_op", 32'(instr_op), 32'(w[31:26]));
            check("sb_rs", 32'(instr_rs), 32'(w[25:21]));
            check("sb_rt", 32'(instr_rt), 32'(w[20:16]));
            check("sb_rd", 32'(instr_rd), 32'(w[15:11]));
            check("sb_shamt", 32'(instr_shamt), 32'(w[10:6]));
            check("sb_funct", 32'(instr_funct), 32'(w[5:0]));
            check("sb_imm", instr_imm_sext, {{16{w[15]}}, w[15:0]});
            check("sb_count", 32'(fetch_count), 32'(exp_count));
          end
          exp_count = exp_count + 16'd1;
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc & ~32'd3);
        end else if (popped) begin
          exp_q.push_back(e + 32'd4);
        end
      end
    end
  end

  // Memory responder: one response per accepted request after mem_lat cycles.
  initial begin
    int          timer;
    logic [31:0] pend_addr;
    timer          = 0;
    pend_addr      = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (!rst_n) begin
        timer = 0;
      end else if (inject_junk) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end else begin
        if (acc_pending) begin
          timer     = (mem_lat == 0) ? int'($urandom_range(3, 1)) : mem_lat;
          pend_addr = acc_addr;
        end
        if (timer > 0) begin
          timer--;
          if (timer == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic found;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_ovr[32'h0] = 32'h8C22_0004;
    mem_ovr[32'h4] = 32'h1000_FFFF;

    // Reset state.
    tick();
    tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_op", 32'(instr_op), 32'd0);
    check("rst_imm", instr_imm_sext, 32'd0);
    check("rst_instr_pc", instr_pc, RESET_PC);
    check("rst_pc_plus4", instr_pc_plus4, RESET_PC + 32'd4);

    // Reset then fetch of 0x8C22_0004 from address 0.
    rst_n = 1'b1;
    #1 check("idle_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("wait_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    check("f1_valid", 32'(instr_valid), 32'd1);
    check("f1_op", 32'(instr_op), 32'h23);
    check("f1_rs", 32'(instr_rs), 32'd1);
    check("f1_rt", 32'(instr_rt), 32'd2);
    check("f1_imm", instr_imm_sext, 32'h0000_0004);
    check("f1_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("f1_done_valid", 32'(instr_valid), 32'd0);
    check("f1_done_count", 32'(fetch_count), 32'd1);
    check("f1_next_req", 32'(imem_req_valid), 32'd1);
    check("f1_next_addr", imem_addr, 32'h4);

    // Backpressure with 0x1000_FFFF held.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_op", 32'(instr_op), 32'h04);
    check("bp_imm", instr_imm_sext, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(instr_valid), 32'd1);
      check("bp_hold_imm", instr_imm_sext, 32'hFFFF_FFFF);
      check("bp_hold_pc", instr_pc, 32'h4);
      check("bp_no_req", 32'(imem_req_valid), 32'd0);
      check("bp_hold_count", 32'(fetch_count), 32'd1);
    end
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 3;
    tick();
    instr_ready = 1'b0;
    check("bp_done_count", 32'(fetch_count), 32'd2);
    check("bp_done_valid", 32'(instr_valid), 32'd0);
    check("bp_next_addr", imem_addr, 32'h8);

    // Redirect while the fetch of address 8 is outstanding.
    tick();
    imem_req_ready = 1'b0;
    check("rw_in_wait", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      check("rw_no_instr", 32'(instr_valid), 32'd0);
      if (imem_req_valid) found = 1'b1;
      else tick();
    end
    if (!found) begin
      tests_run++;
      tests_failed++;
      $display("FAIL rw_timeout: no refetch request within 8 cycles");
    end
    check("rw_addr", imem_addr, 32'h40);

    // Redirect in HOLD without a handshake: squashed, not counted.
    mem_lat        = 1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    check("h1_valid", 32'(instr_valid), 32'd1);
    check("h1_pc", instr_pc, 32'h40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    check("h1_squash", 32'(instr_valid), 32'd0);
    check("h1_count", 32'(fetch_count), 32'd2);
    check("h1_req", 32'(imem_req_valid), 32'd1);
    check("h1_addr", imem_addr, 32'h100);

    // Redirect in HOLD with a simultaneous handshake: delivered and counted.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    check("h2_valid", 32'(instr_valid), 32'd1);
    check("h2_pc", instr_pc, 32'h100);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    check("h2_count", 32'(fetch_count), 32'd3);
    check("h2_valid_low", 32'(instr_valid), 32'd0);
    check("h2_addr", imem_addr, 32'h100);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    check("wrap_valid", 32'(instr_valid), 32'd1);
    check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", instr_pc_plus4, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("wrap_next_addr", imem_addr, 32'h0);
    check("wrap_count", 32'(fetch_count), 32'd4);

    // Asynchronous reset while a fetch is outstanding.
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_count", 32'(fetch_count), 32'd0);
    check("ar_valid", 32'(instr_valid), 32'd0);
    check("ar_req", 32'(imem_req_valid), 32'd0);
    check("ar_addr", imem_addr, RESET_PC);
    check("ar_op", 32'(instr_op), 32'd0);
    tick();
    tick();
    rst_n       = 1'b1;
    inject_junk = 1'b1;
    check("ar_idle_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    inject_junk = 1'b0;
    check("ar_req_after", 32'(imem_req_valid), 32'd1);
    check("ar_req_addr", imem_addr, RESET_PC);
    check("ar_no_instr", 32'(instr_valid), 32'd0);
    mem_lat        = 1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    check("ar_f_valid", 32'(instr_valid), 32'd1);
    check("ar_f_op", 32'(instr_op), 32'h23);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Randomized traffic against the scoreboard.
    mem_lat = 0;
    for (int c = 0; c < 4000; c++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      instr_ready    = ($urandom_range(2, 0) != 0);
      redirect_valid = ($urandom_range(15, 0) == 0);
      redirect_pc    = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                   : ($urandom & 32'h0000_0FFF);
      tick();
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("final_count", 32'(fetch_count), 32'(exp_count));
    check("rand_progress", 32'(deliveries > 500), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
